// File: rtl/byte_ram_responder.sv
// byte_ram_responder: byte-wide single-port RAM serving a 1-byte fetch port and a serialised LB/LH/LW/SB/SH/SW data port
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   if_addr_i     fetch byte address; if_data_o is the byte there one edge later (held while stalled)
//   if_stall_o    high while the data port owns the RAM
//   mem_req_i     level request held until mem_done_o; mem_we_i store/load; mem_size_i 00 B, 01 H, 1x W
//   mem_addr_i    data byte address, any alignment; mem_wdata_i byte k stored at addr+k
//   mem_rdata_o   zero-extended little-endian load data, 0 after a store
//   mem_done_o    one-cycle completion pulse; mem_busy_o high from the cycle after acceptance through done
module byte_ram_responder #(
    parameter int ADDR_WIDTH = 17
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] if_addr_i,
    output logic [7:0]  if_data_o,
    output logic        if_stall_o,
    input  logic        mem_req_i,
    input  logic        mem_we_i,
    input  logic [1:0]  mem_size_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_wdata_i,
    output logic [31:0] mem_rdata_o,
    output logic        mem_done_o,
    output logic        mem_busy_o
);
    localparam int AW = ADDR_WIDTH;
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] XFER = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
    logic [1:0]    state;
    logic [AW-1:0] addr_q;
    logic          we_q;
    logic [31:0]   wdata_q;
    logic [1:0]    idx;
    logic [1:0]    last_q;
    logic [31:0]   rbuf;
    logic [7:0]    ram [2**AW];
    logic [AW-1:0] a;
    logic          unused_addr_bits;
    // byte address of the current beat; the add wraps naturally at the RAM size
    assign a = addr_q + AW'(idx);
    assign unused_addr_bits = ^{if_addr_i[31:AW], mem_addr_i[31:AW]};
    assign mem_done_o = state == DONE;
    assign mem_busy_o = state != IDLE;
    assign if_stall_o = state != IDLE;
    // rbuf is cleared on acceptance, so stores report 0 and loads are zero-extended
    assign mem_rdata_o = rbuf;
    // the RAM has no reset; a reset edge suppresses the pending byte so an aborted store stops at once
    always_ff @(posedge clk)
        if (!rst && state == XFER && we_q) ram[a] <= wdata_q[{idx, 3'b000} +: 8];
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            if_data_o <= '0;
            rbuf      <= '0;
            idx       <= '0;
            last_q    <= '0;
            addr_q    <= '0;
            we_q      <= 1'b0;
            wdata_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if_data_o <= ram[if_addr_i[AW-1:0]];
                    if (mem_req_i) begin
                        addr_q  <= mem_addr_i[AW-1:0];
                        we_q    <= mem_we_i;
                        wdata_q <= mem_wdata_i;
                        last_q  <= mem_size_i == 2'b00 ? 2'd0 : mem_size_i == 2'b01 ? 2'd1 : 2'd3;
                        idx     <= '0;
                        rbuf    <= '0;
                        state   <= XFER;
                    end
                end
                XFER: begin
                    if (!we_q) rbuf[{idx, 3'b000} +: 8] <= ram[a];
                    idx <= idx + 2'd1;
                    if (idx == last_q) state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_byte_ram_responder.sv
// tb_byte_ram_responder: directed and random data-port transfers checked against a byte-array model, with fetch stall/freeze checks
module tb_byte_ram_responder;
    localparam int AW = 17;
    localparam int M = (1 << AW) - 1;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] if_addr_i = '0;
    logic [7:0]  if_data_o;
    logic        if_stall_o;
    logic        mem_req_i = 1'b0;
    logic        mem_we_i = 1'b0;
    logic [1:0]  mem_size_i = '0;
    logic [31:0] mem_addr_i = '0;
    logic [31:0] mem_wdata_i = '0;
    logic [31:0] mem_rdata_o;
    logic        mem_done_o;
    logic        mem_busy_o;
    int          passed = 0;
    int          total = 0;
    logic [7:0]  mdl [int];

    byte_ram_responder #(.ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst), .if_addr_i(if_addr_i), .if_data_o(if_data_o), .if_stall_o(if_stall_o),
        .mem_req_i(mem_req_i), .mem_we_i(mem_we_i), .mem_size_i(mem_size_i), .mem_addr_i(mem_addr_i),
        .mem_wdata_i(mem_wdata_i), .mem_rdata_o(mem_rdata_o), .mem_done_o(mem_done_o), .mem_busy_o(mem_busy_o)
    );

    always #5 clk = ~clk;

    function automatic int key(input logic [31:0] a);
        return int'(a & 32'(M));
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] a, input int nb);
        logic [31:0] r = '0;
        for (int k = 0; k < 4; k++)
            if (k < nb) r[8*k +: 8] = mdl[key(a + 32'(k))];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        total++;
        assert (o === e) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, o, e);
    endtask

    task automatic xfer(input string tag, input logic we, input logic [1:0] sz, input logic [31:0] a,
                        input logic [31:0] wd, input int flo, input int fhi);
        int nb, dk, stall;
        bit known, seen;
        logic [7:0] frz;
        logic [31:0] exp_r;
        nb = sz == 2'b00 ? 1 : sz == 2'b01 ? 2 : 4;
        exp_r = we ? 32'h0 : model_load(a, nb);
        @(negedge clk);
        known = mdl.exists(key(if_addr_i));
        frz = known ? mdl[key(if_addr_i)] : 8'h0;
        mem_req_i = 1'b1;
        mem_we_i = we;
        mem_size_i = sz;
        mem_addr_i = a;
        mem_wdata_i = wd;
        seen = 0;
        dk = -1;
        stall = 0;
        for (int k = 0; k < 12 && !seen; k++) begin
            @(posedge clk);
            #1;
            if (if_stall_o) stall++;
            if (known) chk({tag, " fetch frozen"}, 32'(if_data_o), 32'(frz));
            if (mem_done_o) begin
                seen = 1;
                dk = k;
            end else if_addr_i = 32'(flo) + 32'($urandom_range(0, fhi - flo));
        end
        mem_req_i = 1'b0;
        chk({tag, " done edge"}, 32'(dk), 32'(nb));
        chk({tag, " stall cycles"}, 32'(stall), 32'(nb + 1));
        chk({tag, " rdata"}, mem_rdata_o, exp_r);
        if (we)
            for (int k = 0; k < nb; k++) mdl[key(a + 32'(k))] = wd[8*k +: 8];
        @(posedge clk);
        #1;
        chk({tag, " done pulse width"}, 32'(mem_done_o), 32'h0);
        chk({tag, " busy after done"}, 32'(mem_busy_o), 32'h0);
        if (known) chk({tag, " fetch held on return"}, 32'(if_data_o), 32'(frz));
        @(posedge clk);
        #1;
        if (mdl.exists(key(if_addr_i)))
            chk({tag, " fetch resumed"}, 32'(if_data_o), 32'(mdl[key(if_addr_i)]));
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset if_data", 32'(if_data_o), 32'h0);
        chk("reset rdata", mem_rdata_o, 32'h0);
        chk("reset done", 32'(mem_done_o), 32'h0);
        chk("reset busy", 32'(mem_busy_o), 32'h0);
        chk("reset stall", 32'(if_stall_o), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        // T1: ram[0..3] = 13,00,00,00 then step the fetch address every 2 cycles
        xfer("T1 init", 1'b1, 2'b10, 32'h0, 32'h0000_0013, 0, 3);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if_addr_i = 32'(i);
            @(posedge clk);
            #1;
            chk("T1 fetch", 32'(if_data_o), i == 0 ? 32'h13 : 32'h0);
            @(posedge clk);
        end
        // T2..T4 directed
        xfer("T2 SW", 1'b1, 2'b10, 32'h100, 32'hDEAD_BEEF, 0, 3);
        xfer("T2 LW", 1'b0, 2'b10, 32'h100, 32'h0, 0, 3);
        chk("T2 word", model_load(32'h100, 4), 32'hDEAD_BEEF);
        xfer("T3 SB", 1'b1, 2'b00, 32'h103, 32'h0000_00AA, 0, 3);
        xfer("T3 LW", 1'b0, 2'b10, 32'h100, 32'h0, 0, 3);
        xfer("T3 LB", 1'b0, 2'b00, 32'h103, 32'h0, 0, 3);
        xfer("T4 SB last", 1'b1, 2'b00, 32'(M), 32'h34, 0, 3);
        xfer("T4 SB zero", 1'b1, 2'b00, 32'h0, 32'h12, 0, 3);
        xfer("T4 LH wrap", 1'b0, 2'b01, 32'hABC1_FFFF, 32'h0, 0, 3);
        // T5: reset during a store aborts after two bytes
        xfer("T5 pre", 1'b1, 2'b10, 32'h200, 32'hAABB_CCDD, 0, 3);
        @(negedge clk);
        mem_req_i = 1'b1;
        mem_we_i = 1'b1;
        mem_size_i = 2'b10;
        mem_addr_i = 32'h200;
        mem_wdata_i = 32'h1122_3344;
        repeat (3) @(posedge clk);
        #1;
        chk("T5 busy before rst", 32'(mem_busy_o), 32'h1);
        chk("T5 done before rst", 32'(mem_done_o), 32'h0);
        rst = 1'b1;
        mem_req_i = 1'b0;
        @(posedge clk);
        #1;
        chk("T5 busy after rst", 32'(mem_busy_o), 32'h0);
        chk("T5 done after rst", 32'(mem_done_o), 32'h0);
        chk("T5 stall after rst", 32'(if_stall_o), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        mdl[32'h200] = 8'h44;
        mdl[32'h201] = 8'h33;
        xfer("T5 LW", 1'b0, 2'b10, 32'h200, 32'h0, 0, 3);
        // window for random traffic, with fetch addresses roaming over it
        for (int i = 0; i < 16; i++)
            xfer("init", 1'b1, 2'b10, 32'h1000 + 32'(4 * i), $urandom, 0, 3);
        for (int i = 0; i < 60; i++)
            xfer("rand", 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                 ($urandom & 32'hFFFE_0000) | (32'h1000 + 32'($urandom_range(0, 60))),
                 $urandom, 32'h1000, 32'h103F);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
